// File: rtl/imu_pkg.sv
// rtl/imu_pkg.sv - shared types and constants for the IMU I2C register reader
// Contents: FSM state enum, byte-phase enum, default IMU address, I2C R/W bit
// values and the quarter-slot indices used to sequence each bit on the bus.
package imu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_TX,
        ST_ACK_CHK,
        ST_RESTART,
        ST_RX,
        ST_NACK,
        ST_STOP,
        ST_FIN
    } state_t;

    // Which byte is on the wire; decides where a good ACK leads.
    typedef enum logic [1:0] {
        BYTE_WADDR,
        BYTE_REG,
        BYTE_RADDR
    } byte_t;

    localparam logic [6:0] IMU_DEV_ADDR = 7'h68;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    // Quarter index within one bit slot.
    localparam logic [1:0] Q_SET    = 2'd0;  // SCL low, change SDA
    localparam logic [1:0] Q_RISE   = 2'd1;  // release SCL
    localparam logic [1:0] Q_SAMPLE = 2'd2;  // SCL high, sample SDA
    localparam logic [1:0] Q_FALL   = 2'd3;  // pull SCL low

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - SCL quarter-period tick and quarter index generator
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   en         count while high; counter and quarter index cleared while low
//   tick       one-clk pulse every CLK_DIV clk cycles while en is high
//   quarter    index of the quarter that the current tick completes
module i2c_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    // The quarter index idles at 3 so the first tick after enabling is the
    // "pull SCL low" quarter that completes a START condition; the slots that
    // follow then begin on quarter 0.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt     <= '0;
            quarter <= 2'd3;
        end else if (tick) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            cnt     <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imu_i2c_reader.sv
// rtl/imu_i2c_reader.sv - I2C master reading one register byte from an IMU
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   start      request a read; sampled only while idle
//   reg_addr   register index, latched when start is accepted
//   data_buff  last byte read without any ACK error
//   busy       transaction in progress
//   done       one-clk pulse at the end of every transaction
//   ack_err    valid with done: some slave ACK was missing
//   scl, sda   open-drain bus lines (drive 0 or release)
module imu_i2c_reader
    import imu_pkg::*;
#(
    parameter int         CLK_DIV  = 25,
    parameter logic [6:0] DEV_ADDR = IMU_DEV_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] reg_addr,
    output logic [7:0] data_buff,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output wire        scl,
    inout  wire        sda
);

    state_t     state;
    byte_t      byte_sel;
    logic [7:0] shreg;
    logic [7:0] reg_lat;
    logic [3:0] bit_cnt;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_smp;
    logic       tick;
    logic [1:0] quarter;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (busy),
        .tick    (tick),
        .quarter (quarter)
    );

    // Open-drain: an enable pulls the line low, otherwise the pull-up wins.
    assign scl = scl_oe ? 1'b0 : 1'bz;
    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_sel  <= BYTE_WADDR;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            data_buff <= 8'h00;
            shreg     <= 8'h00;
            reg_lat   <= 8'h00;
            bit_cnt   <= 4'd0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            sda_smp   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    scl_oe <= 1'b0;
                    sda_oe <= 1'b0;
                    if (start) begin
                        reg_lat  <= reg_addr;
                        busy     <= 1'b1;
                        ack_err  <= 1'b0;
                        // SDA falls now with SCL high: the START edge itself.
                        sda_oe   <= 1'b1;
                        shreg    <= {DEV_ADDR, I2C_WRITE};
                        byte_sel <= BYTE_WADDR;
                        bit_cnt  <= 4'd0;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    // START hold time is one quarter, then SCL goes low.
                    if (tick) begin
                        scl_oe <= 1'b1;
                        state  <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (tick) begin
                        case (quarter)
                            Q_SET:  sda_oe <= ~shreg[7];
                            Q_RISE: scl_oe <= 1'b0;
                            Q_FALL: begin
                                scl_oe <= 1'b1;
                                shreg  <= {shreg[6:0], 1'b0};
                                if (bit_cnt == 4'd7) begin
                                    bit_cnt <= 4'd0;
                                    state   <= ST_ACK_CHK;
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_ACK_CHK: begin
                    if (tick) begin
                        case (quarter)
                            Q_SET:    sda_oe  <= 1'b0;
                            Q_RISE:   scl_oe  <= 1'b0;
                            Q_SAMPLE: sda_smp <= sda;
                            Q_FALL: begin
                                scl_oe <= 1'b1;
                                if (sda_smp) begin
                                    ack_err <= 1'b1;
                                    state   <= ST_STOP;
                                end else begin
                                    case (byte_sel)
                                        BYTE_WADDR: begin
                                            shreg    <= reg_lat;
                                            byte_sel <= BYTE_REG;
                                            state    <= ST_TX;
                                        end
                                        BYTE_REG: state <= ST_RESTART;
                                        default: begin
                                            shreg <= 8'h00;
                                            state <= ST_RX;
                                        end
                                    endcase
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_RESTART: begin
                    if (tick) begin
                        case (quarter)
                            Q_SET:    sda_oe <= 1'b0;
                            Q_RISE:   scl_oe <= 1'b0;
                            Q_SAMPLE: sda_oe <= 1'b1;
                            Q_FALL: begin
                                scl_oe   <= 1'b1;
                                shreg    <= {DEV_ADDR, I2C_READ};
                                byte_sel <= BYTE_RADDR;
                                state    <= ST_TX;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_RX: begin
                    if (tick) begin
                        case (quarter)
                            Q_SET:    sda_oe <= 1'b0;
                            Q_RISE:   scl_oe <= 1'b0;
                            Q_SAMPLE: shreg  <= {shreg[6:0], sda};
                            Q_FALL: begin
                                scl_oe <= 1'b1;
                                if (bit_cnt == 4'd7) begin
                                    bit_cnt <= 4'd0;
                                    state   <= ST_NACK;
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_NACK: begin
                    // Master leaves SDA released for the 9th bit: single-byte read.
                    if (tick) begin
                        case (quarter)
                            Q_SET:  sda_oe <= 1'b0;
                            Q_RISE: scl_oe <= 1'b0;
                            Q_FALL: begin
                                scl_oe <= 1'b1;
                                state  <= ST_STOP;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_STOP: begin
                    // SDA low under SCL low, SCL up, then SDA rises: STOP.
                    if (tick) begin
                        case (quarter)
                            Q_SET:  sda_oe <= 1'b1;
                            Q_RISE: scl_oe <= 1'b0;
                            Q_SAMPLE: begin
                                sda_oe <= 1'b0;
                                state  <= ST_FIN;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_FIN: begin
                    if (!ack_err) begin
                        data_buff <= shreg;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imu_i2c_reader.sv
// tb/tb_imu_i2c_reader.sv - directed bench for imu_i2c_reader with a behavioural IMU slave
module tb_imu_i2c_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] data_buff;
    logic       busy;
    logic       done;
    logic       ack_err;
    wire        scl;
    wire        sda;

    int errors = 0;
    int checks = 0;

    pullup (scl);
    pullup (sda);

    imu_i2c_reader #(
        .CLK_DIV  (2),
        .DEV_ADDR (7'h68)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reg_addr  (reg_addr),
        .data_buff (data_buff),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .scl       (scl),
        .sda       (sda)
    );

    always #5 clk = ~clk;

    // Behavioural IMU slave, oversampling the bus on the falling clk edge.
    logic       slave_present = 1'b1;
    logic       s_drive = 1'b0;
    int         s_phase = 0;   // 0 idle, 1 address, 2 register write, 3 read, 4 write done
    int         bitn = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] txb = 8'h00;
    logic [7:0] sreg = 8'h00;
    logic       acked = 1'b0;
    logic       m_ack = 1'b0;
    logic       ps = 1'b1;
    logic       pd = 1'b1;
    logic       cs, cd;
    int         n_start = 0;
    int         n_stop = 0;
    logic [7:0] bus_bytes[$];

    assign sda = s_drive ? 1'b0 : 1'bz;

    function automatic logic [7:0] regval(input logic [7:0] a);
        case (a)
            8'h25:   return 8'hA5;
            8'h3B:   return 8'h5C;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        cs = scl;
        cd = sda;
        if (rst) begin
            s_phase = 0;
            s_drive = 1'b0;
            bitn    = 0;
        end else if (ps && cs && pd && !cd) begin
            s_phase = 1;
            bitn    = 0;
            sh      = 8'h00;
            s_drive = 1'b0;
            n_start++;
        end else if (ps && cs && !pd && cd) begin
            s_phase = 0;
            s_drive = 1'b0;
            n_stop++;
        end else if (!ps && cs) begin
            if (s_phase == 1 || s_phase == 2) begin
                if (bitn < 8) begin
                    sh = {sh[6:0], cd};
                    bitn++;
                    if (bitn == 8) bus_bytes.push_back(sh);
                end else begin
                    bitn = 9;
                end
            end else if (s_phase == 3) begin
                bitn++;
                if (bitn == 9) m_ack = cd;
            end
        end else if (ps && !cs) begin
            if (s_phase == 1 || s_phase == 2) begin
                if (bitn == 8) begin
                    acked   = (s_phase == 1) ? (slave_present && sh[7:1] == 7'h68) : slave_present;
                    s_drive = acked;
                end else if (bitn == 9) begin
                    s_drive = 1'b0;
                    bitn    = 0;
                    if (!acked) begin
                        s_phase = 0;
                    end else if (s_phase == 2) begin
                        sreg    = sh;
                        s_phase = 4;
                    end else if (sh[0]) begin
                        s_phase = 3;
                        txb     = regval(sreg);
                        s_drive = !txb[7];
                    end else begin
                        s_phase = 2;
                    end
                end
            end else if (s_phase == 3) begin
                if (bitn >= 1 && bitn <= 7) s_drive = !txb[7 - bitn];
                else if (bitn == 8) s_drive = 1'b0;
                else if (bitn == 9) s_phase = 0;
            end
        end
        ps = cs;
        pd = cd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int got, input int lo, input int hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus_log();
        bus_bytes.delete();
        n_start = 0;
        n_stop  = 0;
        m_ack   = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] ra);
        @(negedge clk);
        reg_addr = ra;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    // Counts clk edges since the accepting edge until done is seen.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            cyc();
            n++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
    endtask

    int n;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_data", data_buff, 8'h00);
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda", sda, 1'b1);
        rst = 1'b0;
        repeat (3) cyc();

        // Read register 0x25
        clear_bus_log();
        pulse_start(8'h25);
        chk("rd1_busy", busy, 1'b1);
        wait_done("rd1", n);
        chk_range("rd1_latency", n, 302, 306);
        chk("rd1_data", data_buff, 8'hA5);
        chk("rd1_ack_err", ack_err, 1'b0);
        chk("rd1_busy_low", busy, 1'b0);
        chk("rd1_nbytes", bus_bytes.size(), 3);
        chk("rd1_byte0", bus_bytes[0], 8'hD0);
        chk("rd1_byte1", bus_bytes[1], 8'h25);
        chk("rd1_byte2", bus_bytes[2], 8'hD1);
        chk("rd1_master_nack", m_ack, 1'b1);
        chk("rd1_starts", n_start, 2);
        chk("rd1_stops", n_stop, 1);
        cyc();
        chk("rd1_done_pulse", done, 1'b0);
        chk("rd1_scl_idle", scl, 1'b1);
        chk("rd1_sda_idle", sda, 1'b1);

        // No slave on the bus
        slave_present = 1'b0;
        clear_bus_log();
        pulse_start(8'h3B);
        wait_done("nack", n);
        chk("nack_ack_err", ack_err, 1'b1);
        chk("nack_data_held", data_buff, 8'hA5);
        chk("nack_nbytes", bus_bytes.size(), 1);
        chk("nack_byte0", bus_bytes[0], 8'hD0);
        chk("nack_starts", n_start, 1);
        chk("nack_stops", n_stop, 1);
        slave_present = 1'b1;
        repeat (4) cyc();

        // start held and reg_addr changed while busy: ignored
        clear_bus_log();
        @(negedge clk);
        reg_addr = 8'h25;
        start    = 1'b1;
        cyc();
        repeat (10) cyc();
        reg_addr = 8'h3B;
        repeat (150) cyc();
        chk("busy_data_held", data_buff, 8'hA5);
        start = 1'b0;
        wait_done("hold", n);
        chk("hold_data", data_buff, 8'hA5);
        chk("hold_ack_err", ack_err, 1'b0);
        chk("hold_byte1", bus_bytes[1], 8'h25);
        chk("hold_starts", n_start, 2);
        chk("hold_stops", n_stop, 1);
        repeat (3) cyc();
        chk("hold_no_requeue", busy, 1'b0);

        // start held through done: back-to-back transaction
        @(negedge clk);
        reg_addr = 8'h3B;
        start    = 1'b1;
        cyc();
        wait_done("b2b1", n);
        cyc();
        chk("b2b_restart_busy", busy, 1'b1);
        start = 1'b0;
        wait_done("b2b2", n);
        chk("b2b_data", data_buff, 8'h5C);
        repeat (4) cyc();

        // Reset during RX
        clear_bus_log();
        pulse_start(8'h25);
        n = 0;
        while (!(s_phase == 3 && bitn >= 3) && n < 1000) begin
            cyc();
            n++;
        end
        chk("rx_reached", (s_phase == 3 && bitn >= 3), 1'b1);
        chk("rx_busy", busy, 1'b1);
        rst = 1'b1;
        cyc();
        chk("rxrst_busy", busy, 1'b0);
        chk("rxrst_done", done, 1'b0);
        chk("rxrst_data", data_buff, 8'h00);
        rst = 1'b0;
        repeat (2) cyc();
        chk("rxrst_scl", scl, 1'b1);
        chk("rxrst_sda", sda, 1'b1);

        // Read 0x3B after the reset
        clear_bus_log();
        pulse_start(8'h3B);
        wait_done("rd2", n);
        chk("rd2_data", data_buff, 8'h5C);
        chk("rd2_ack_err", ack_err, 1'b0);
        chk("rd2_byte1", bus_bytes[1], 8'h3B);
        chk("rd2_stops", n_stop, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
